pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Consumes the combinational hazard request from the decode-stage hazard detector, branch/jump redirects resolved in ID, and start/done from the multi-cycle multiply/divide unit in EX.
- Produces the write-enables, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Keeps a saturating stall-cycle counter and a consecutive-stall watchdog for debug.

---
 rtl/pipeline_stall_controller_pkg.sv | 41 ++++
 rtl/pipeline_stall_controller_stall_watchdog.sv | 67 ++++++
 rtl/pipeline_stall_controller.sv | 108 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - state_e    : sequencer state encoding (2'b11 is illegal and recovers to run)
//   - ctrl_t     : bundle of the pipeline register controls driven by the sequencer
//   - Ctrl*      : canned control patterns used by the output decode
//   - DEFAULT_*  : default counter sizing, shared with the debug/perf counter block
package pipeline_stall_controller_pkg;

    localparam int unsigned DEFAULT_CNT_W     = 16;
    localparam int unsigned DEFAULT_MAX_STALL = 64;

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StMulWait  = 2'b01,
        StMulDrain = 2'b10
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_hold;
    } ctrl_t;

    // Free-running pipeline.
    localparam ctrl_t CtrlFlow     = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, ex_hold: 1'b0};
    // Freeze front end, insert a bubble into EX (load-use / operand hazard, reset).
    localparam ctrl_t CtrlBubble   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b1, ex_hold: 1'b0};
    // Redirect: fetch target, squash the wrong-path instruction in IF/ID.
    localparam ctrl_t CtrlRedirect = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_bubble: 1'b0, ex_hold: 1'b0};
    // Multi-cycle op in EX: freeze everything up to and including EX/MEM.
    localparam ctrl_t CtrlMulHold  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, ex_hold: 1'b1};
    // Drain: front end still frozen, EX result allowed to move into MEM.
    localparam ctrl_t CtrlDrain    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, ex_hold: 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_stall_watchdog.sv
// Stall statistics and watchdog for the pipeline stall controller.
//   clk_i           : pipeline clock
//   rst_ni          : asynchronous active-low reset
//   pc_write_i      : PC load enable; a cycle with pc_write_i=0 is a stalled cycle
//   stall_count_o   : saturating count of stalled cycles
//   stall_timeout_o : sticky flag, set once MAX_STALL consecutive stalled cycles are seen
module pipeline_stall_controller_stall_watchdog
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned CNT_W     = DEFAULT_CNT_W,
    parameter int unsigned MAX_STALL = DEFAULT_MAX_STALL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pc_write_i,
    output logic [CNT_W-1:0] stall_count_o,
    output logic             stall_timeout_o
);

    if (MAX_STALL < 2 || MAX_STALL >= (64'd1 << CNT_W)) begin : g_bad_params
        $error("MAX_STALL must be >= 2 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] StallLim = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        consec_d    = consec_q;
        timeout_d   = timeout_q;

        if (!pc_write_i && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Run of consecutive stalls; any progress cycle restarts the run.
        if (pc_write_i) begin
            consec_d = '0;
        end else if (consec_q != StallLim) begin
            consec_d = consec_q + CNT_W'(1);
        end

        if (consec_d == StallLim) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_count_o   = stall_cnt_q;
    assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Outputs are Mealy: they depend on the current state and this cycle's hazard/redirect/mul
// inputs with zero latency, since the hazard detector feeding HazardReq is combinational.
//   Clk, Rst      : clock, asynchronous active-low reset
//   HazardReq     : load-use / branch-operand stall request from decode
//   BranchTaken   : branch resolved taken in ID
//   JumpTaken     : j/jal/jr in ID
//   MulStart      : multi-cycle op entering EX
//   MulDone       : multi-cycle result valid
//   PCWrite       : PC load enable
//   IF_ID_Write   : IF/ID load enable
//   IF_ID_Flush   : zero IF/ID on next edge
//   ID_EX_Bubble  : zero ID/EX control bits on next edge
//   EX_Hold       : hold ID/EX and EX/MEM contents
//   StallCount    : saturating count of cycles with PCWrite=0
//   StallTimeout  : sticky consecutive-stall watchdog flag
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned CNT_W     = DEFAULT_CNT_W,
    parameter int unsigned MAX_STALL = DEFAULT_MAX_STALL
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             HazardReq,
    input  logic             BranchTaken,
    input  logic             JumpTaken,
    input  logic             MulStart,
    input  logic             MulDone,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_Hold,
    output logic [CNT_W-1:0] StallCount,
    output logic             StallTimeout
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        ctrl    = CtrlFlow;

        unique case (state_q)
            StRun: begin
                // Mul start wins over everything: ID re-evaluates its hazard/redirect
                // once the multi-cycle op releases the pipeline.
                if (MulStart) begin
                    ctrl    = CtrlMulHold;
                    state_d = StMulWait;
                end else if (HazardReq) begin
                    // Branch operands are not yet valid, so a same-cycle redirect is dropped.
                    ctrl = CtrlBubble;
                end else if (BranchTaken || JumpTaken) begin
                    ctrl = CtrlRedirect;
                end
            end
            StMulWait: begin
                ctrl = CtrlMulHold;
                if (MulDone) begin
                    state_d = StMulDrain;
                end
            end
            StMulDrain: begin
                ctrl    = CtrlDrain;
                state_d = StRun;
            end
            default: begin
                // Illegal encoding: stall safely for one cycle and recover to run.
                ctrl    = CtrlBubble;
                state_d = StRun;
            end
        endcase

        // Reset is asynchronous on the outputs too, not only on the state.
        if (!Rst) begin
            ctrl = CtrlBubble;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Bubble = ctrl.id_ex_bubble;
    assign EX_Hold      = ctrl.ex_hold;

    pipeline_stall_controller_stall_watchdog #(
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk_i           (Clk),
        .rst_ni          (Rst),
        .pc_write_i      (ctrl.pc_write),
        .stall_count_o   (StallCount),
        .stall_timeout_o (StallTimeout)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard = 1'b0, branch = 1'b0, jump = 1'b0, mul_start = 1'b0, mul_done = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold;
    logic [15:0] stall_count;
    logic        stall_timeout;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ex_hold;
    logic [3:0]  s_stall_count;
    logic        s_stall_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller dut (
        .Clk          (clk),
        .Rst          (rst_n),
        .HazardReq    (hazard),
        .BranchTaken  (branch),
        .JumpTaken    (jump),
        .MulStart     (mul_start),
        .MulDone      (mul_done),
        .PCWrite      (pc_write),
        .IF_ID_Write  (if_id_write),
        .IF_ID_Flush  (if_id_flush),
        .ID_EX_Bubble (id_ex_bubble),
        .EX_Hold      (ex_hold),
        .StallCount   (stall_count),
        .StallTimeout (stall_timeout)
    );

    // Narrow-counter instance for the saturation case.
    pipeline_stall_controller #(
        .CNT_W     (4),
        .MAX_STALL (8)
    ) dut_small (
        .Clk          (clk),
        .Rst          (rst_n),
        .HazardReq    (hazard),
        .BranchTaken  (branch),
        .JumpTaken    (jump),
        .MulStart     (mul_start),
        .MulDone      (mul_done),
        .PCWrite      (s_pc_write),
        .IF_ID_Write  (s_if_id_write),
        .IF_ID_Flush  (s_if_id_flush),
        .ID_EX_Bubble (s_id_ex_bubble),
        .EX_Hold      (s_ex_hold),
        .StallCount   (s_stall_count),
        .StallTimeout (s_stall_timeout)
    );

    // in  = {hazard, branch, jump, mul_start, mul_done}
    // exp = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold}
    typedef struct {
        string      name;
        logic [4:0] in;
        logic [4:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] in);
        {hazard, branch, jump, mul_start, mul_done} = in;
    endtask

    task automatic chk_outs(input string name, input logic [4:0] exp);
        chk(name, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold},
            {27'd0, exp});
        chk({name, "_inv_flush_bubble"}, {31'd0, if_id_flush & id_ex_bubble}, 32'd0);
        chk({name, "_inv_hold"}, {31'd0, ex_hold & (pc_write | if_id_write)}, 32'd0);
    endtask

    // Apply inputs just after an edge, compare mid-cycle, then advance one edge.
    task automatic step(input string name, input logic [4:0] in, input logic [4:0] exp);
        set_in(in);
        #1;
        chk_outs(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    localparam logic [4:0] OFlow   = 5'b11000;
    localparam logic [4:0] OBubble = 5'b00010;
    localparam logic [4:0] ORedir  = 5'b11100;
    localparam logic [4:0] OHold   = 5'b00001;
    localparam logic [4:0] ODrain  = 5'b00000;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"idle",              5'b00000, OFlow};
        vecs[1]  = '{"hazard",            5'b10000, OBubble};
        vecs[2]  = '{"hazard_branch",     5'b11000, OBubble};
        vecs[3]  = '{"branch",            5'b01000, ORedir};
        vecs[4]  = '{"jump",              5'b00100, ORedir};
        vecs[5]  = '{"muldone_in_run",    5'b00001, OFlow};
        vecs[6]  = '{"mulstart_priority", 5'b11110, OHold};
        vecs[7]  = '{"wait_ignores_all",  5'b11110, OHold};
        vecs[8]  = '{"wait_muldone",      5'b00001, OHold};
        vecs[9]  = '{"drain_branch",      5'b01000, ODrain};
        vecs[10] = '{"branch_jump",       5'b01100, ORedir};
        vecs[11] = '{"idle_after",        5'b00000, OFlow};

        // Reset state, inputs set to try to disturb it.
        rst_n = 1'b0;
        set_in(5'b11111);
        #2;
        chk_outs("reset_outs", OBubble);
        chk("reset_count", {16'd0, stall_count}, 32'd0);
        chk("reset_timeout", {31'd0, stall_timeout}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_count_held", {16'd0, stall_count}, 32'd0);

        // Table-driven priority/FSM vectors.
        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].in, vecs[i].exp);
        end
        chk("table_stall_count", {16'd0, stall_count}, 32'd6);
        chk("table_small_count", {28'd0, s_stall_count}, 32'd6);

        // Load-use: one bubble cycle then free flow.
        do_reset();
        step("lu_stall", 5'b10000, OBubble);
        step("lu_release", 5'b00000, OFlow);
        chk("lu_count", {16'd0, stall_count}, 32'd1);

        // Multiply: start cycle 0, done cycle 5, branch pulses during 1..6 ignored.
        do_reset();
        step("mul_c0", 5'b00010, OHold);
        for (int c = 1; c <= 4; c++) begin
            step($sformatf("mul_c%0d", c), (c % 2 == 1) ? 5'b01000 : 5'b10100, OHold);
        end
        step("mul_c5_done", 5'b01001, OHold);
        step("mul_c6_drain", 5'b01000, ODrain);
        step("mul_c7_run", 5'b00000, OFlow);
        chk("mul_count", {16'd0, stall_count}, 32'd7);

        // Watchdog: 64 consecutive stalled edges.
        do_reset();
        step("wd_start", 5'b00010, OHold);
        for (int c = 1; c < 63; c++) begin
            set_in(5'b00000);
            @(posedge clk);
            #1;
        end
        chk("wd_not_yet", {31'd0, stall_timeout}, 32'd0);
        @(posedge clk);
        #1;
        chk("wd_set_64", {31'd0, stall_timeout}, 32'd1);
        step("wd_done", 5'b00001, OHold);
        step("wd_drain", 5'b00000, ODrain);
        step("wd_run", 5'b00000, OFlow);
        chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        do_reset();
        chk("wd_cleared", {31'd0, stall_timeout}, 32'd0);

        // Saturation on the 4-bit instance: 20 hazard cycles.
        for (int c = 0; c < 20; c++) begin
            set_in(5'b10000);
            @(posedge clk);
            #1;
        end
        chk("sat_small", {28'd0, s_stall_count}, 32'd15);
        chk("sat_wide", {16'd0, stall_count}, 32'd20);
        chk("sat_small_timeout", {31'd0, s_stall_timeout}, 32'd1);

        // Async reset in MUL_WAIT, dropped and released between edges.
        do_reset();
        step("ar_start", 5'b00010, OHold);
        step("ar_wait", 5'b00000, OHold);
        chk("ar_count_before", {16'd0, stall_count}, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("ar_outs", OBubble);
        chk("ar_count", {16'd0, stall_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk_outs("ar_released_run", OFlow);
        chk("ar_count_released", {16'd0, stall_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
